// File: rtl/dense_out_serializer.sv
// Captures a flattened N_ELEMS x ELEM_W result vector and streams it element by element over valid/ready.
// Optional `DENSE_SER_ARGMAX_EN appends one beat carrying the argmax index of each vector.
module dense_out_serializer #(
  parameter int N_ELEMS = 64,
  parameter int ELEM_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_ELEMS*ELEM_W-1:0]   vec_in,
  input  logic                        vec_in_valid,
  output logic [ELEM_W-1:0]           byte_out,
  output logic                        byte_out_valid,
  input  logic                        byte_out_ready,
  output logic                        byte_out_last,
  output logic                        busy,
  output logic                        overflow
);

`ifdef DENSE_SER_ARGMAX_EN
  localparam int N_BEATS = N_ELEMS + 1;
`else
  localparam int N_BEATS = N_ELEMS;
`endif
  localparam int VEC_W = N_ELEMS * ELEM_W;
  localparam int CNT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] STREAM      = 2'd1;
  localparam logic [1:0] STREAM_PEND = 2'd2;

  logic [1:0]       state_p0, state_nxt;
  logic [CNT_W-1:0] cnt_p0, cnt_nxt;
  logic             overflow_p0;
  logic [VEC_W-1:0] act_sr_p0;
  logic [VEC_W-1:0] pend_p0;

  logic act_full, xfer, fin;
  logic ld_act_in, ld_act_pend, ld_pend, drop;

  always_comb begin
    act_full    = (state_p0 != IDLE);
    xfer        = act_full && byte_out_ready;
    fin         = xfer && (cnt_p0 == LAST_BEAT);
    ld_act_in   = vec_in_valid && ((state_p0 == IDLE) || ((state_p0 == STREAM) && fin));
    ld_act_pend = (state_p0 == STREAM_PEND) && fin;
    ld_pend     = vec_in_valid && (((state_p0 == STREAM) && !fin) ||
                                   ((state_p0 == STREAM_PEND) && fin));
    drop        = vec_in_valid && (state_p0 == STREAM_PEND) && !fin;

    state_nxt = state_p0;
    case (state_p0)
      IDLE:        state_nxt = vec_in_valid ? STREAM : IDLE;
      STREAM:      if (fin) state_nxt = vec_in_valid ? STREAM : IDLE;
                   else     state_nxt = vec_in_valid ? STREAM_PEND : STREAM;
      STREAM_PEND: if (fin) state_nxt = vec_in_valid ? STREAM_PEND : STREAM;
      default:     state_nxt = IDLE;
    endcase

    // A fresh vector always restarts at beat 0, whether it came from the input or the pending slot
    cnt_nxt = cnt_p0;
    if (ld_act_in || ld_act_pend) cnt_nxt = '0;
    else if (xfer)                cnt_nxt = cnt_p0 + CNT_W'(1);
  end

  // Stage p0: control state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= IDLE;
      cnt_p0      <= '0;
      overflow_p0 <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      if (drop) overflow_p0 <= 1'b1;
    end
  end

  // Stage p0: vector storage (data only, qualified by the control state)
  always_ff @(posedge clk) begin
    if (ld_act_in)        act_sr_p0 <= vec_in;
    else if (ld_act_pend) act_sr_p0 <= pend_p0;
    else if (xfer)        act_sr_p0 <= act_sr_p0 >> ELEM_W;
    if (ld_pend) pend_p0 <= vec_in;
  end

`ifdef DENSE_SER_ARGMAX_EN
  logic [ELEM_W-1:0] max_val_p0;
  logic [CNT_W-1:0]  max_idx_p0;
  logic [ELEM_W-1:0] cur_elem;
  logic              data_beat;

  always_comb begin
    cur_elem  = act_sr_p0[ELEM_W-1:0];
    data_beat = (cnt_p0 < CNT_W'(N_ELEMS));
  end

  // Beat 0 reseeds the tracker; strict compare keeps the lowest index on ties
  always_ff @(posedge clk) begin
    if (xfer && data_beat && ((cnt_p0 == '0) || (cur_elem > max_val_p0))) begin
      max_val_p0 <= cur_elem;
      max_idx_p0 <= cnt_p0;
    end
  end

  always_comb begin
    byte_out = '0;
    if (act_full) byte_out = data_beat ? cur_elem : ELEM_W'(max_idx_p0);
  end
`else
  always_comb begin
    byte_out = act_full ? act_sr_p0[ELEM_W-1:0] : '0;
  end
`endif

  always_comb begin
    byte_out_valid = act_full;
    byte_out_last  = act_full && (cnt_p0 == LAST_BEAT);
    busy           = act_full;
    overflow       = overflow_p0;
  end

endmodule

// File: tb/tb_dense_out_serializer.sv
// Scoreboard bench for dense_out_serializer: directed vectors push expected beats, a negedge monitor checks them.
module tb_dense_out_serializer;
  localparam int N = 64;
  localparam int W = 8;
`ifdef DENSE_SER_ARGMAX_EN
  localparam int NB = N + 1;
`else
  localparam int NB = N;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] vec_in;
  logic           vec_in_valid;
  logic [W-1:0]   byte_out;
  logic           byte_out_valid;
  logic           byte_out_ready;
  logic           byte_out_last;
  logic           busy;
  logic           overflow;

  dense_out_serializer #(.N_ELEMS(N), .ELEM_W(W)) dut (
    .clk(clk), .rst(rst), .vec_in(vec_in), .vec_in_valid(vec_in_valid),
    .byte_out(byte_out), .byte_out_valid(byte_out_valid), .byte_out_ready(byte_out_ready),
    .byte_out_last(byte_out_last), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_count = 0;
  int first_hs = 0;
  int last_hs = 0;
  logic [W:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: hold-stability while stalled, and in-order beat comparison on each handshake
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_b = '0;
  logic         prev_l = 1'b0;
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if (byte_out_valid !== 1'b1 || byte_out !== prev_b || byte_out_last !== prev_l) begin
          bad++;
          $display("FAIL hold: got v=%0b b=%0h l=%0b, need v=1 b=%0h l=%0b",
                   byte_out_valid, byte_out, byte_out_last, prev_b, prev_l);
        end
      end
      if (byte_out_valid && byte_out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat: got b=%0h l=%0b, need no beat", byte_out, byte_out_last);
        end else begin
          e = exp_q.pop_front();
          if ({byte_out, byte_out_last} !== e) begin
            bad++;
            $display("FAIL beat%0d: got b=%0h l=%0b, need b=%0h l=%0b",
                     hs_count, byte_out, byte_out_last, e[W:1], e[0]);
          end
        end
        hs_count++;
        if (hs_count == 1) first_hs = cyc;
        last_hs = cyc;
      end
      prev_stall = byte_out_valid && !byte_out_ready;
      prev_b = byte_out;
      prev_l = byte_out_last;
    end
  end

  task automatic check(input string name, input int got, input int need);
    total++;
    if (got != need) begin
      bad++;
      $display("FAIL %s: got %0d, need %0d", name, got, need);
    end
  endtask

  task automatic push_vec(input logic [N*W-1:0] v);
    logic [W-1:0] mx;
    int idx;
    mx = v[W-1:0];
    idx = 0;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back({v[i*W +: W], (NB == N && i == N-1)});
      if (v[i*W +: W] > mx) begin
        mx = v[i*W +: W];
        idx = i;
      end
    end
    if (NB != N) exp_q.push_back({W'(idx), 1'b1});
  endtask

  task automatic strobe(input logic [N*W-1:0] v);
    vec_in = v;
    vec_in_valid = 1'b1;
    @(posedge clk); #1;
    vec_in_valid = 1'b0;
  endtask

  task automatic capture(input logic [N*W-1:0] v);
    @(posedge clk); #1;
    strobe(v);
  endtask

  task automatic wait_hs(input int n, input string name);
    int k;
    k = 0;
    while (hs_count < n && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_timeout"}, int'(hs_count >= n), 1);
  endtask

  task automatic drain(input bit toggle, input string name);
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && !busy) && k < 1000) begin
      @(posedge clk); #1;
      if (toggle) byte_out_ready = ~byte_out_ready;
      k++;
    end
    check({name, "_drain"}, int'(k < 1000), 1);
  endtask

  logic [N*W-1:0] va, vb, vc;

  initial begin
    rst = 1'b1;
    vec_in = '0;
    vec_in_valid = 1'b0;
    byte_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", byte_out_valid, 0);
    check("rst_last", byte_out_last, 0);
    check("rst_byte", byte_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    // Capture coincident with reset must be ignored
    for (int i = 0; i < N; i++) va[i*W +: W] = 8'hA5;
    vec_in = va;
    vec_in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vec_in_valid = 1'b0;
    check("rst_cap_busy", busy, 0);
    check("rst_cap_valid", byte_out_valid, 0);

    // Basic stream
    for (int i = 0; i < N; i++) va[i*W +: W] = W'(i);
    byte_out_ready = 1'b1;
    hs_count = 0;
    push_vec(va);
    capture(va);
    check("lat_valid", byte_out_valid, 1);
    check("lat_byte", byte_out, 0);
    check("basic_busy", busy, 1);
    drain(1'b0, "basic");
    check("basic_gap", last_hs - first_hs, NB - 1);
    check("basic_busy_fall", cyc - last_hs, 1);
    check("basic_count", hs_count, NB);

    // Backpressure: ready toggles every cycle
    for (int i = 0; i < N; i++) va[i*W +: W] = W'((1 + 3*i) % 256);
    hs_count = 0;
    push_vec(va);
    byte_out_ready = 1'b0;
    capture(va);
    byte_out_ready = 1'b1;
    drain(1'b1, "bp");
    check("bp_span", last_hs - first_hs, 2*(NB-1));
    byte_out_ready = 1'b1;

    // Back-to-back via pending slot
    for (int i = 0; i < N; i++) begin
      va[i*W +: W] = 8'h11;
      vb[i*W +: W] = 8'h22;
    end
    hs_count = 0;
    push_vec(va);
    push_vec(vb);
    capture(va);
    repeat (4) @(posedge clk);
    #1;
    strobe(vb);
    drain(1'b0, "b2b");
    check("b2b_span", last_hs - first_hs, 2*NB - 1);
    check("b2b_ovf", overflow, 0);

    // Capture on the final handshake, pending empty
    for (int i = 0; i < N; i++) vb[i*W +: W] = W'(8'hC0 + i);
    hs_count = 0;
    push_vec(va);
    push_vec(vb);
    capture(va);
    wait_hs(NB-1, "coin_e");
    strobe(vb);
    drain(1'b0, "coin_e");
    check("coin_e_span", last_hs - first_hs, 2*NB - 1);

    // Capture on the final handshake, pending full
    for (int i = 0; i < N; i++) vc[i*W +: W] = W'(255 - i);
    hs_count = 0;
    push_vec(va);
    push_vec(vb);
    push_vec(vc);
    capture(va);
    capture(vb);
    wait_hs(NB-1, "coin_f");
    strobe(vc);
    drain(1'b0, "coin_f");
    check("coin_f_span", last_hs - first_hs, 3*NB - 1);
    check("coin_f_ovf", overflow, 0);

    // Overflow: third vector dropped while stalled
    for (int i = 0; i < N; i++) begin
      va[i*W +: W] = 8'h33;
      vb[i*W +: W] = 8'h44;
      vc[i*W +: W] = 8'h55;
    end
    byte_out_ready = 1'b0;
    hs_count = 0;
    push_vec(va);
    push_vec(vb);
    capture(va);
    capture(vb);
    check("ovf_before", overflow, 0);
    capture(vc);
    check("ovf_after", overflow, 1);
    byte_out_ready = 1'b1;
    drain(1'b0, "ovf");
    repeat (3) @(posedge clk);
    #1;
    check("ovf_count", hs_count, 2*NB);
    check("ovf_sticky", overflow, 1);

    // Reset mid-stream after beat 20
    for (int i = 0; i < N; i++) va[i*W +: W] = W'(i + 100);
    hs_count = 0;
    for (int i = 0; i <= 20; i++) exp_q.push_back({W'(i + 100), 1'b0});
    capture(va);
    wait_hs(21, "mid");
    rst = 1'b1;
    byte_out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_valid", byte_out_valid, 0);
    check("mid_busy", busy, 0);
    check("mid_ovf", overflow, 0);
    check("mid_q", exp_q.size(), 0);
    for (int i = 0; i < N; i++) va[i*W +: W] = W'(i) ^ 8'h5A;
    byte_out_ready = 1'b1;
    hs_count = 0;
    push_vec(va);
    capture(va);
    check("mid_first", byte_out, 8'h5A);
    drain(1'b0, "mid");
    check("mid_count", hs_count, NB);

`ifdef DENSE_SER_ARGMAX_EN
    // Argmax: tie at 200 resolves to lowest index 17
    for (int i = 0; i < N; i++) va[i*W +: W] = W'(i);
    va[17*W +: W] = 8'd200;
    va[40*W +: W] = 8'd200;
    hs_count = 0;
    for (int i = 0; i < N; i++) exp_q.push_back({va[i*W +: W], 1'b0});
    exp_q.push_back({8'd17, 1'b1});
    capture(va);
    drain(1'b0, "amax");
    check("amax_count", hs_count, N + 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, need finished");
    $fatal(1, "timeout");
  end
endmodule
